// File: rtl/ascon_op_sequencer.sv
// Control sequencer for an Ascon permutation datapath: starts an operation on a
// ready level, walks init/key-XOR/round/writeback phases and reports done/error.
module ascon_op_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_operation_ready,
  input  logic [2:0] i_operation_mode,
  input  logic       i_state_shift_en,
  output logic       o_operation_done,
  output logic       o_busy,
  output logic       o_round_en,
  output logic [3:0] o_round_idx,
  output logic       o_state_init_en,
  output logic       o_key_xor_en,
  output logic [1:0] o_key_xor_sel,
  output logic       o_reg_128b_wrback_en,
  output logic [1:0] o_reg_128b_wrback_sel,
  output logic       o_error,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT_LOAD = 3'd1,
    S_PRE_XOR   = 3'd2,
    S_ROUNDS    = 3'd3,
    S_POST_XOR  = 3'd4,
    S_WRBACK    = 3'd5,
    S_DONE      = 3'd6,
    S_WAIT_CLR  = 3'd7
  } state_t;

  localparam logic [2:0] M_NOP        = 3'b000;
  localparam logic [2:0] M_PERM12     = 3'b001;
  localparam logic [2:0] M_PERM8      = 3'b010;
  localparam logic [2:0] M_PERM6      = 3'b011;
  localparam logic [2:0] M_AEAD_INIT  = 3'b100;
  localparam logic [2:0] M_AEAD_FINAL = 3'b101;

  state_t     r_state;
  logic [2:0] r_mode;
  logic [3:0] r_cnt;
  logic       r_error;
  logic       r_busy;
  logic       r_done;
  logic       r_round_en;
  logic       r_init_en;
  logic       r_kx_en;
  logic [1:0] r_kx_sel;
  logic       r_wb_en;
  logic       w_conflict;
  logic       w_keep;

  // A datapath write while a strobe state is active kills that cycle's strobes.
  assign w_conflict = i_state_shift_en && (r_state inside
                      {S_INIT_LOAD, S_PRE_XOR, S_ROUNDS, S_POST_XOR, S_WRBACK});
  assign w_keep     = ~w_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_mode     <= M_NOP;
      r_cnt      <= 4'd0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_round_en <= 1'b0;
      r_init_en  <= 1'b0;
      r_kx_en    <= 1'b0;
      r_kx_sel   <= 2'b00;
      r_wb_en    <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_round_en <= 1'b0;
      r_init_en  <= 1'b0;
      r_kx_en    <= 1'b0;
      r_kx_sel   <= 2'b00;
      r_wb_en    <= 1'b0;
      if (w_conflict) begin
        r_state <= S_DONE;
        r_done  <= 1'b1;
        r_error <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_operation_ready) begin
              r_mode  <= i_operation_mode;
              r_error <= 1'b0;
              r_busy  <= 1'b1;
              case (i_operation_mode)
                M_PERM12, M_PERM8, M_PERM6: begin
                  r_state    <= S_ROUNDS;
                  r_round_en <= 1'b1;
                  r_cnt      <= (i_operation_mode == M_PERM12) ? 4'd0 :
                                (i_operation_mode == M_PERM8)  ? 4'd4 : 4'd6;
                end
                M_AEAD_INIT: begin
                  r_state   <= S_INIT_LOAD;
                  r_init_en <= 1'b1;
                end
                M_AEAD_FINAL: begin
                  r_state  <= S_PRE_XOR;
                  r_kx_en  <= 1'b1;
                  r_kx_sel <= 2'b10;
                end
                M_NOP: begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                end
                default: begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_error <= 1'b1;
                end
              endcase
            end
          end
          S_INIT_LOAD, S_PRE_XOR: begin
            r_state    <= S_ROUNDS;
            r_round_en <= 1'b1;
            r_cnt      <= 4'd0;
          end
          S_ROUNDS: begin
            if (r_cnt == 4'd11) begin
              if (r_mode == M_AEAD_INIT || r_mode == M_AEAD_FINAL) begin
                r_state  <= S_POST_XOR;
                r_kx_en  <= 1'b1;
                r_kx_sel <= 2'b01;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt      <= r_cnt + 4'd1;
              r_round_en <= 1'b1;
            end
          end
          S_POST_XOR: begin
            if (r_mode == M_AEAD_FINAL) begin
              r_state <= S_WRBACK;
              r_wb_en <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_WRBACK: begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
          S_DONE: begin
            r_state <= S_WAIT_CLR;
            r_busy  <= 1'b0;
          end
          S_WAIT_CLR: begin
            if (!i_operation_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_operation_done      = r_done;
  assign o_busy                = r_busy;
  assign o_error               = r_error;
  assign o_round_en            = r_round_en & w_keep;
  assign o_round_idx           = (r_round_en & w_keep) ? r_cnt : 4'd0;
  assign o_state_init_en       = r_init_en & w_keep;
  assign o_key_xor_en          = r_kx_en & w_keep;
  assign o_key_xor_sel         = w_keep ? r_kx_sel : 2'b00;
  assign o_reg_128b_wrback_en  = r_wb_en & w_keep;
  assign o_reg_128b_wrback_sel = (r_wb_en & w_keep) ? 2'b10 : 2'b00;
  assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_ascon_op_sequencer.sv
// Bench for ascon_op_sequencer: table of operations with a per-cycle expected
// output trace, plus hand sequences for held ready and mid-operation reset.
module tb_ascon_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_operation_ready;
  logic [2:0] i_operation_mode;
  logic       i_state_shift_en;
  logic       o_operation_done;
  logic       o_busy;
  logic       o_round_en;
  logic [3:0] o_round_idx;
  logic       o_state_init_en;
  logic       o_key_xor_en;
  logic [1:0] o_key_xor_sel;
  logic       o_reg_128b_wrback_en;
  logic [1:0] o_reg_128b_wrback_sel;
  logic       o_error;
  logic [2:0] o_dbg_state;

  always #5 clk = ~clk;

  ascon_op_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .i_operation_ready     (i_operation_ready),
    .i_operation_mode      (i_operation_mode),
    .i_state_shift_en      (i_state_shift_en),
    .o_operation_done      (o_operation_done),
    .o_busy                (o_busy),
    .o_round_en            (o_round_en),
    .o_round_idx           (o_round_idx),
    .o_state_init_en       (o_state_init_en),
    .o_key_xor_en          (o_key_xor_en),
    .o_key_xor_sel         (o_key_xor_sel),
    .o_reg_128b_wrback_en  (o_reg_128b_wrback_en),
    .o_reg_128b_wrback_sel (o_reg_128b_wrback_sel),
    .o_error               (o_error),
    .o_dbg_state           (o_dbg_state)
  );

  localparam int W = 15;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd7;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0] mode;
    int         conflict;
    int         hold;
    int         done_cyc;
    logic       err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_out();
    return {o_operation_done, o_busy, o_round_en, o_round_idx, o_state_init_en,
            o_key_xor_en, o_key_xor_sel, o_reg_128b_wrback_en, o_reg_128b_wrback_sel, o_error};
  endfunction

  function automatic logic [W-1:0] mk(input logic d, input logic b, input logic r,
                                      input logic [3:0] idx, input logic ini, input logic kx,
                                      input logic [1:0] ks, input logic wb, input logic e);
    logic [1:0] wsel;
    wsel = wb ? 2'b10 : 2'b00;
    return {d, b, r, idx, ini, kx, ks, wb, wsel, e};
  endfunction

  // Expected trace for cycles 1..end: active phases, DONE, then WAIT_CLR cycles.
  task automatic build_expected(input logic [2:0] mode, input int conflict, input int hold,
                                output int done_cyc);
    logic [W-1:0] seq[$];
    logic err;
    seq = {};
    err = (mode >= 3'd6);
    case (mode)
      3'd1: for (int i = 0; i < 12; i++) seq.push_back(mk(0,1,1,4'(i),0,0,2'b00,0,0));
      3'd2: for (int i = 4; i < 12; i++) seq.push_back(mk(0,1,1,4'(i),0,0,2'b00,0,0));
      3'd3: for (int i = 6; i < 12; i++) seq.push_back(mk(0,1,1,4'(i),0,0,2'b00,0,0));
      3'd4: begin
        seq.push_back(mk(0,1,0,4'd0,1,0,2'b00,0,0));
        for (int i = 0; i < 12; i++) seq.push_back(mk(0,1,1,4'(i),0,0,2'b00,0,0));
        seq.push_back(mk(0,1,0,4'd0,0,1,2'b01,0,0));
      end
      3'd5: begin
        seq.push_back(mk(0,1,0,4'd0,0,1,2'b10,0,0));
        for (int i = 0; i < 12; i++) seq.push_back(mk(0,1,1,4'(i),0,0,2'b00,0,0));
        seq.push_back(mk(0,1,0,4'd0,0,1,2'b01,0,0));
        seq.push_back(mk(0,1,0,4'd0,0,0,2'b00,1,0));
      end
      default: ;
    endcase
    if (conflict > 0 && conflict <= seq.size()) begin
      while (seq.size() >= conflict) void'(seq.pop_back());
      seq.push_back(mk(0,1,0,4'd0,0,0,2'b00,0,0));
      err = 1'b1;
    end
    foreach (seq[i]) exp_q.push_back(seq[i]);
    exp_q.push_back(mk(1,1,0,4'd0,0,0,2'b00,0,err));
    done_cyc = seq.size() + 1;
    for (int i = 0; i <= hold; i++) exp_q.push_back(mk(0,0,0,4'd0,0,0,2'b00,0,err));
  endtask

  task automatic run_op(input vec_t v);
    int n_done;
    int done_at;
    int done_cnt;
    int total;
    logic [W-1:0] exp;
    @(negedge clk);
    i_operation_ready = 1'b1;
    i_operation_mode  = v.mode;
    i_state_shift_en  = 1'b0;
    exp_q = {};
    build_expected(v.mode, v.conflict, v.hold, n_done);
    total = exp_q.size();
    done_at = 0;
    done_cnt = 0;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      i_operation_mode = 3'($urandom_range(0, 7));
      if (k >= n_done) i_state_shift_en = 1'($urandom_range(0, 1));
      else i_state_shift_en = (k == v.conflict);
      if (k == total) i_operation_ready = 1'b0;
      #1;
      exp = exp_q.pop_front();
      check($sformatf("trace m%0d c%0d cyc%0d", v.mode, v.conflict, k), 32'(pack_out()), 32'(exp));
      if (o_operation_done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (v.hold > 0 && k > n_done)
        check($sformatf("wait_state cyc%0d", k), 32'(o_dbg_state), 32'(ST_WAIT));
    end
    @(negedge clk);
    i_state_shift_en = 1'b0;
    #1;
    check($sformatf("done_cycle m%0d", v.mode), done_at, v.done_cyc);
    check($sformatf("done_pulses m%0d", v.mode), done_cnt, 1);
    check($sformatf("error m%0d", v.mode), 32'(o_error), 32'(v.err));
    check($sformatf("back_idle m%0d", v.mode), 32'(o_dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    vecs[0]  = '{mode: 3'd1, conflict: 0,  hold: 0, done_cyc: 13, err: 1'b0};
    vecs[1]  = '{mode: 3'd2, conflict: 0,  hold: 0, done_cyc: 9,  err: 1'b0};
    vecs[2]  = '{mode: 3'd3, conflict: 0,  hold: 0, done_cyc: 7,  err: 1'b0};
    vecs[3]  = '{mode: 3'd4, conflict: 0,  hold: 0, done_cyc: 15, err: 1'b0};
    vecs[4]  = '{mode: 3'd5, conflict: 0,  hold: 0, done_cyc: 16, err: 1'b0};
    vecs[5]  = '{mode: 3'd0, conflict: 0,  hold: 0, done_cyc: 1,  err: 1'b0};
    vecs[6]  = '{mode: 3'd7, conflict: 0,  hold: 0, done_cyc: 1,  err: 1'b1};
    vecs[7]  = '{mode: 3'd0, conflict: 0,  hold: 0, done_cyc: 1,  err: 1'b0};
    vecs[8]  = '{mode: 3'd1, conflict: 4,  hold: 0, done_cyc: 5,  err: 1'b1};
    vecs[9]  = '{mode: 3'd0, conflict: 0,  hold: 0, done_cyc: 1,  err: 1'b0};
    vecs[10] = '{mode: 3'd6, conflict: 0,  hold: 0, done_cyc: 1,  err: 1'b1};
    vecs[11] = '{mode: 3'd5, conflict: 1,  hold: 0, done_cyc: 2,  err: 1'b1};
    vecs[12] = '{mode: 3'd4, conflict: 14, hold: 0, done_cyc: 15, err: 1'b1};
    vecs[13] = '{mode: 3'd5, conflict: 15, hold: 5, done_cyc: 16, err: 1'b1};

    rst_n = 1'b0;
    i_operation_ready = 1'b0;
    i_operation_mode  = 3'd0;
    i_state_shift_en  = 1'b0;
    #1;
    check("reset_outputs", 32'(pack_out()), 32'd0);
    check("reset_state", 32'(o_dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i]);

    // Held ready on a plain PERM6: FSM parks in WAIT_CLR, single done.
    run_op('{mode: 3'd3, conflict: 0, hold: 5, done_cyc: 7, err: 1'b0});

    // Reset during the 5th round of AEAD_INIT.
    @(negedge clk);
    i_operation_ready = 1'b1;
    i_operation_mode  = 3'd4;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    #1;
    check("pre_reset_round_en", 32'(o_round_en), 32'd1);
    check("pre_reset_round_idx", 32'(o_round_idx), 32'd4);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(pack_out()), 32'd0);
    check("async_reset_state", 32'(o_dbg_state), 32'(ST_IDLE));
    i_operation_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_reset_quiet cyc%0d", k), 32'(pack_out()), 32'd0);
    end

    run_op('{mode: 3'd1, conflict: 0, hold: 0, done_cyc: 13, err: 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
